// File: rtl/fc_addr_demux.sv
// -----------------------------------------------------------------------------
// fc_addr_demux
//
// Address-decoded N-way demultiplexer for a TCDM-style core bus. One slave
// port (core side) is steered to one of N_PORTS master ports. The target is
// the lowest-numbered port whose window [ADDR_START, ADDR_END) contains the
// address. Addresses that hit no window go to an internal error port that
// grants at once and answers one cycle later with ERR_RDATA and s_r_err_o.
//
// Outstanding transactions all belong to one port at a time (cur_q). A
// request to a different port stalls until every outstanding response has
// returned, so responses always come back in issue order.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   s_req_i .. s_be_i       slave request channel (core side)
//   s_gnt_o                 slave grant (combinational)
//   s_r_valid_o/rdata/err   slave response (combinational from real ports,
//                           registered for the error port)
//   m_req_o                 one-hot per-port request
//   m_add/wen/wdata/be_o    request fields broadcast to every port
//   m_gnt_i                 per-port grant
//   m_r_valid_i/rdata_i     per-port response
//   protocol_err_o          registered pulse after an unexpected response
// -----------------------------------------------------------------------------
module fc_addr_demux #(
  parameter int unsigned                    N_PORTS         = 2,
  parameter int unsigned                    ADDR_WIDTH      = 32,
  parameter int unsigned                    MAX_OUTSTANDING = 2,
  parameter logic [N_PORTS*ADDR_WIDTH-1:0]  ADDR_START      = {32'h1C08_0000, 32'h1C00_0000},
  parameter logic [N_PORTS*ADDR_WIDTH-1:0]  ADDR_END        = {32'h1C09_0000, 32'h1C08_0000},
  parameter logic [31:0]                    ERR_RDATA       = 32'hBADA_CCE5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // slave (core) side
  input  logic                          s_req_i,
  input  logic [ADDR_WIDTH-1:0]         s_add_i,
  input  logic                          s_wen_i,
  input  logic [31:0]                   s_wdata_i,
  input  logic [3:0]                    s_be_i,
  output logic                          s_gnt_o,
  output logic                          s_r_valid_o,
  output logic [31:0]                   s_r_rdata_o,
  output logic                          s_r_err_o,
  // master (memory) side
  output logic [N_PORTS-1:0]            m_req_o,
  output logic [N_PORTS*ADDR_WIDTH-1:0] m_add_o,
  output logic [N_PORTS-1:0]            m_wen_o,
  output logic [N_PORTS*32-1:0]         m_wdata_o,
  output logic [N_PORTS*4-1:0]          m_be_o,
  input  logic [N_PORTS-1:0]            m_gnt_i,
  input  logic [N_PORTS-1:0]            m_r_valid_i,
  input  logic [N_PORTS*32-1:0]         m_r_rdata_i,
  output logic                          protocol_err_o
);

  localparam int unsigned    CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned    PW       = $clog2(N_PORTS + 1);
  localparam logic [PW-1:0]  ERR_PORT = PW'(N_PORTS);
  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      cur_q, cur_d;
  logic               err_pend_q, err_pend_d;
  logic               prot_err_q, prot_err_d;

  logic [N_PORTS-1:0] hit_s;
  logic [PW-1:0]      target_s;
  logic               cur_valid_s;
  logic [31:0]        cur_rdata_s;
  logic               tgt_gnt_s;
  logic               unexp_s;
  logic               real_rsp_s;
  logic               rsp_s;
  logic [CW-1:0]      cnt_eff_s;
  logic               issue_s;
  logic [N_PORTS-1:0] m_req_s;
  logic               gnt_s;

  // Request fields go to every port unchanged; only m_req_o selects.
  assign m_add_o   = {N_PORTS{s_add_i}};
  assign m_wen_o   = {N_PORTS{s_wen_i}};
  assign m_wdata_o = {N_PORTS{s_wdata_i}};
  assign m_be_o    = {N_PORTS{s_be_i}};

  // Window decode; scanning from the top down leaves the lowest hit winning.
  always_comb begin
    target_s = ERR_PORT;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      hit_s[i] = (s_add_i >= ADDR_START[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                 (s_add_i <  ADDR_END[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
      target_s = hit_s[i] ? PW'(i) : target_s;
    end
  end

  // Per-port selection: response of the owning port, grant of the target
  // port, and detection of responses nobody is waiting for.
  always_comb begin
    cur_valid_s = 1'b0;
    cur_rdata_s = 32'h0;
    tgt_gnt_s   = 1'b0;
    unexp_s     = 1'b0;
    for (int j = 0; j < int'(N_PORTS); j++) begin
      if (cur_q == PW'(j)) begin
        cur_valid_s = m_r_valid_i[j];
        cur_rdata_s = m_r_rdata_i[j*32 +: 32];
      end else begin
        cur_valid_s = cur_valid_s;
        cur_rdata_s = cur_rdata_s;
      end
      tgt_gnt_s = (target_s == PW'(j)) ? m_gnt_i[j] : tgt_gnt_s;
      // Only the owner may answer, and only while something is outstanding.
      unexp_s   = unexp_s |
                  (m_r_valid_i[j] & ~((cnt_q != CNT_ZERO) & (cur_q == PW'(j))));
    end
  end

  // Response forwarding, then issue check using the post-response count so
  // a full or switching request is released in the same cycle.
  always_comb begin
    real_rsp_s = (cnt_q != CNT_ZERO) && (cur_q != ERR_PORT) && cur_valid_s;
    rsp_s      = real_rsp_s || err_pend_q;
    cnt_eff_s  = cnt_q - CW'(rsp_s);
    issue_s    = s_req_i && (cnt_eff_s < MAX_CNT) &&
                 ((cnt_eff_s == CNT_ZERO) || (target_s == cur_q));
    for (int j = 0; j < int'(N_PORTS); j++) begin
      m_req_s[j] = issue_s && (target_s == PW'(j));
    end
    if (target_s == ERR_PORT) begin
      gnt_s = issue_s;
    end else begin
      gnt_s = issue_s && tgt_gnt_s;
    end
  end

  // Next-state for the outstanding tracker and the error-port pipeline.
  always_comb begin
    cnt_d      = cnt_q + CW'(gnt_s) - CW'(rsp_s);
    cur_d      = gnt_s ? target_s : cur_q;
    err_pend_d = gnt_s && (target_s == ERR_PORT);
    prot_err_d = unexp_s;
  end

  // Tracker state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= CNT_ZERO;
      cur_q      <= {PW{1'b0}};
      err_pend_q <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      err_pend_q <= err_pend_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign m_req_o        = m_req_s;
  assign s_gnt_o        = gnt_s;
  assign s_r_valid_o    = rsp_s;
  assign s_r_err_o      = err_pend_q;
  assign s_r_rdata_o    = err_pend_q ? ERR_RDATA : (real_rsp_s ? cur_rdata_s : 32'h0);
  assign protocol_err_o = prot_err_q;

endmodule

// File: tb/tb_fc_addr_demux.sv
// Testbench for fc_addr_demux: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-queue reference model.
module tb_fc_addr_demux;

  localparam int          NP   = 2;
  localparam int          MAXO = 2;
  localparam int          EP   = 2;   // error port index in the model
  localparam logic [31:0] ERRD = 32'hBADA_CCE5;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               s_req_i = 1'b0;
  logic [31:0]        s_add_i = 32'h0;
  logic               s_wen_i = 1'b0;
  logic [31:0]        s_wdata_i = 32'h0;
  logic [3:0]         s_be_i = 4'h0;
  logic               s_gnt_o;
  logic               s_r_valid_o;
  logic [31:0]        s_r_rdata_o;
  logic               s_r_err_o;
  logic [1:0]         m_req_o;
  logic [63:0]        m_add_o;
  logic [1:0]         m_wen_o;
  logic [63:0]        m_wdata_o;
  logic [7:0]         m_be_o;
  logic [1:0]         m_gnt_i = 2'b00;
  logic [1:0]         m_r_valid_i = 2'b00;
  logic [63:0]        m_r_rdata_i = 64'h0;
  logic               protocol_err_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: ports of granted-but-unanswered transactions in
  // issue order, whether an error-port answer is due, expected error pulse.
  int outq[$];
  bit e_due    = 1'b0;
  bit prot_exp = 1'b0;

  fc_addr_demux #(
    .N_PORTS(2), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2),
    .ADDR_START({32'h1C08_0000, 32'h1C00_0000}),
    .ADDR_END({32'h1C09_0000, 32'h1C08_0000}),
    .ERR_RDATA(32'hBADA_CCE5)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
    .s_wdata_i(s_wdata_i), .s_be_i(s_be_i), .s_gnt_o(s_gnt_o),
    .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o), .s_r_err_o(s_r_err_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
    .m_wdata_o(m_wdata_o), .m_be_o(m_be_o), .m_gnt_i(m_gnt_i),
    .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    logic [31:0] lo [2];
    logic [31:0] hi [2];
    lo[0] = 32'h1C00_0000; hi[0] = 32'h1C08_0000;
    lo[1] = 32'h1C08_0000; hi[1] = 32'h1C09_0000;
    for (int i = 0; i < 2; i++) begin
      if (a >= lo[i] && a < hi[i]) return i;
    end
    return EP;
  endfunction

  // One clock cycle: drive at the falling edge, check settled outputs,
  // then advance the model to what the next rising edge commits.
  task automatic step(input logic req, input logic [31:0] add, input logic wen,
                      input logic [1:0] gnt, input logic [1:0] rv);
    logic [31:0] wd, rd0, rd1, exp_rd;
    logic [3:0]  be;
    logic [1:0]  exp_mreq;
    logic        exp_rv, exp_err, exp_gnt, perr_next;
    int          tgt, owner, n;
    wd  = $urandom;
    be  = 4'($urandom_range(0, 15));
    rd0 = $urandom;
    rd1 = $urandom;
    @(negedge clk_i);
    s_req_i = req; s_add_i = add; s_wen_i = wen; s_wdata_i = wd; s_be_i = be;
    m_gnt_i = gnt; m_r_valid_i = rv; m_r_rdata_i = {rd1, rd0};
    #1;
    check_val("perr", protocol_err_o, prot_exp);

    tgt   = decode(add);
    owner = (outq.size() > 0) ? outq[0] : -1;
    exp_rv = 1'b0; exp_rd = 32'h0; exp_err = 1'b0;
    if (owner == EP) begin
      if (e_due) begin exp_rv = 1'b1; exp_rd = ERRD; exp_err = 1'b1; end
    end else if (owner >= 0 && rv[owner]) begin
      exp_rv = 1'b1;
      exp_rd = (owner == 1) ? rd1 : rd0;
    end
    if (exp_rv) void'(outq.pop_front());
    perr_next = 1'b0;
    for (int j = 0; j < NP; j++) begin
      if (rv[j] && j != owner) perr_next = 1'b1;
    end

    exp_gnt = 1'b0; exp_mreq = 2'b00;
    n = outq.size();
    if (req && n < MAXO && (n == 0 || outq[n-1] == tgt)) begin
      if (tgt == EP) exp_gnt = 1'b1;
      else begin exp_mreq[tgt] = 1'b1; exp_gnt = gnt[tgt]; end
    end

    check_val("gnt",    s_gnt_o, exp_gnt);
    check_val("mreq",   m_req_o, exp_mreq);
    check_val("rvalid", s_r_valid_o, exp_rv);
    check_val("rdata",  s_r_rdata_o, exp_rd);
    check_val("rerr",   s_r_err_o, exp_err);
    check_val("badd",   m_add_o, {add, add});
    check_val("bwen",   m_wen_o, {wen, wen});
    check_val("bwdata", m_wdata_o, {wd, wd});
    check_val("bbe",    m_be_o, {be, be});

    e_due = exp_gnt && (tgt == EP);
    if (exp_gnt) outq.push_back(tgt);
    prot_exp = perr_next;
  endtask

  task automatic idle(input logic [1:0] rv);
    step(1'b0, 32'h0, 1'b1, 2'b00, rv);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    s_req_i = 1'b0; m_gnt_i = 2'b00; m_r_valid_i = 2'b00;
    #1;
    check_val("rst_gnt",    s_gnt_o, 1'b0);
    check_val("rst_mreq",   m_req_o, 2'b00);
    check_val("rst_rvalid", s_r_valid_o, 1'b0);
    check_val("rst_rdata",  s_r_rdata_o, 32'h0);
    check_val("rst_rerr",   s_r_err_o, 1'b0);
    check_val("rst_perr",   protocol_err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    outq.delete();
    e_due = 1'b0;
    prot_exp = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2: a = 32'h1C00_0000 + 32'($urandom_range(0, 32'h7FFFF));
      3, 4:    a = 32'h1C08_0000 + 32'($urandom_range(0, 32'hFFFF));
      5:       a = 32'h1C07_FFFF;
      6:       a = 32'h1C08_0000;
      7:       a = 32'h1C09_0000;
      8:       a = 32'h1BFF_FFFF;
      default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    logic [1:0] rv, g;
    int owner;
    do_reset();

    // Mapped read to port0, answered the next cycle.
    step(1'b1, 32'h1C00_0010, 1'b1, 2'b01, 2'b00);
    idle(2'b01);

    // Outstanding limit: two grants, third held until a response frees a slot.
    step(1'b1, 32'h1C00_0020, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C00_0024, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C00_0028, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C00_0028, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C00_0028, 1'b1, 2'b11, 2'b01);
    idle(2'b01);
    idle(2'b01);

    // Port switch stalls until port0 drains; order port0 then port1.
    step(1'b1, 32'h1C00_0100, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C08_0004, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C08_0004, 1'b1, 2'b11, 2'b00);
    step(1'b1, 32'h1C08_0004, 1'b1, 2'b11, 2'b01);
    idle(2'b10);

    // Unmapped read, then back-to-back unmapped writes at the window edge.
    step(1'b1, 32'h0000_0000, 1'b1, 2'b00, 2'b00);
    idle(2'b00);
    step(1'b1, 32'h1C09_0000, 1'b0, 2'b00, 2'b00);
    step(1'b1, 32'h1C09_0000, 1'b0, 2'b00, 2'b00);
    step(1'b1, 32'h1BFF_FFFC, 1'b0, 2'b00, 2'b00);
    idle(2'b00);

    // Spurious response with nothing outstanding.
    idle(2'b10);
    idle(2'b00);
    idle(2'b00);

    // Reset with two outstanding; late response flagged, port1 granted at once.
    step(1'b1, 32'h1C00_0200, 1'b1, 2'b01, 2'b00);
    step(1'b1, 32'h1C00_0204, 1'b1, 2'b01, 2'b00);
    do_reset();
    step(1'b1, 32'h1C08_0010, 1'b1, 2'b10, 2'b01);
    idle(2'b10);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      owner = (outq.size() > 0) ? outq[0] : -1;
      rv = 2'b00;
      if (owner >= 0 && owner < NP && $urandom_range(0, 2) == 0) rv[owner] = 1'b1;
      if ($urandom_range(0, 24) == 0) rv[$urandom_range(0, 1)] = 1'b1;
      g[0] = ($urandom_range(0, 3) != 0);
      g[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), g, rv);
    end
    idle(2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fc_addr_demux.md
# fc_addr_demux

Parametrised N-way address-decoded demultiplexer for the fabric-controller core's instruction and data buses. It replaces the fixed two-way L2/SCM split. One TCDM-style slave port (core side) is steered to one of N_PORTS master ports by a per-port address window. Outstanding transactions are tracked so responses return in order, and unmapped accesses are terminated with an error response instead of silently aliasing to L2.

## Interface
- N_PORTS, 2: number of master ports (1..8).
- ADDR_WIDTH, 32: address width.
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions (1..15).
- ADDR_START, packed N_PORTS*ADDR_WIDTH: inclusive window start per port; slice i belongs to port i.
- ADDR_END, packed N_PORTS*ADDR_WIDTH: exclusive window end per port.
- ERR_RDATA, 32'hBADACCE5: read data returned on unmapped access.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_req_i  in  1  slave request
- s_add_i  in  ADDR_WIDTH  request address
- s_wen_i  in  1  1 = read, 0 = write
- s_wdata_i  in  32  write data
- s_be_i  in  4  byte enables
- s_gnt_o  out  1  grant
- s_r_valid_o  out  1  response valid
- s_r_rdata_o  out  32  response data
- s_r_err_o  out  1  response is an unmapped-access error
- m_req_o  out  N_PORTS  per-port request
- m_add_o  out  N_PORTS*ADDR_WIDTH  per-port address (broadcast)
- m_wen_o  out  N_PORTS  per-port wen (broadcast)
- m_wdata_o  out  N_PORTS*32  per-port wdata (broadcast)
- m_be_o  out  N_PORTS*4  per-port be (broadcast)
- m_gnt_i  in  N_PORTS  per-port grant
- m_r_valid_i  in  N_PORTS  per-port response valid
- m_r_rdata_i  in  N_PORTS*32  per-port response data
- protocol_err_o  out  1  one-cycle pulse on an unexpected response

## Operation
- Decode: the target is the lowest i with ADDR_START[i] <= s_add_i < ADDR_END[i]. If no window matches, the target is the internal error port E (index N_PORTS).
- State: cnt_q (width $clog2(MAX_OUTSTANDING+1)) and cur_q (index of the port owning the outstanding transactions, 0..N_PORTS).
- Issue allowed when s_req_i && cnt_q < MAX_OUTSTANDING && (cnt_q == 0 || target == cur_q).
- Port switching: a request to a different port stalls, with no m_req and s_gnt_o = 0, until cnt_q == 0. This guarantees in-order responses.
- Real port target with issue allowed: m_req_o[target] = 1 and s_gnt_o = m_gnt_i[target]. All other m_req_o bits are 0.
- Target E with issue allowed: s_gnt_o = 1 the same cycle and no m_req_o bit is asserted.
- On s_req_i && s_gnt_o: cur_q <= target and cnt_q increments.
- Response from a real port: s_r_valid_o = m_r_valid_i[cur_q] when cnt_q > 0, with s_r_rdata_o = m_r_rdata_i[cur_q] and s_r_err_o = 0.
- Response from E: valid exactly one cycle after its grant, with rdata = ERR_RDATA and s_r_err_o = 1. Writes are also answered, with the same rdata.
- cnt_q decrements on every forwarded response. Grant and response in the same cycle leave cnt_q unchanged.
- m_r_valid_i[j] with j != cur_q, or with cnt_q == 0, is dropped (not forwarded) and protocol_err_o pulses for one cycle.

## Timing
- Reset: cnt_q = 0, cur_q = 0, E response pipeline cleared. All outputs 0 except the broadcast buses, which are combinational from the slave inputs.
- Request path is fully combinational (s_req → m_req, m_gnt → s_gnt), so there is zero added request latency.
- Response path from real ports is combinational. Responses from E have one cycle of latency.
- Full (cnt_q == MAX_OUTSTANDING): s_gnt_o = 0 and m_req_o = 0. The grant is released in the same cycle a response arrives, because the decrement is evaluated before the issue check.
- The E port supports back-to-back grants. Each grant produces one response in the following cycle.
- Reset asserted mid-transaction clears all tracking. Late responses after reset are dropped and flagged by protocol_err_o.

## Test plan
- Two windows (port0 0x1C000000–0x1C080000, port1 0x1C080000–0x1C090000): read 0x1C000010 with gnt and r_valid the next cycle → only m_req_o[0] asserted, rdata forwarded, s_r_err_o = 0.
- MAX_OUTSTANDING = 2, port0 never responds: three back-to-back reads → two grants, third held with s_gnt_o = 0 until a response arrives, then granted in that same cycle.
- Read port0 (outstanding), then a request to port1 → m_req_o[1] stays 0 until port0 responds, then port1 is granted; response order is port0 then port1.
- Read 0x00000000 (unmapped) → s_gnt_o = 1 same cycle, next cycle s_r_valid_o = 1, s_r_rdata_o = 0xBADACCE5, s_r_err_o = 1, no m_req_o.
- Inject m_r_valid_i[1] while cnt_q = 0 → no s_r_valid_o, protocol_err_o pulses once.
- Assert rst_ni low with 2 outstanding → cnt_q = 0. A following request to a different port is granted immediately.
